// File: rtl/mbox_pkg.sv
// mbox_pkg: shared widths, sequencer state and request-op encodings for the mbox request path
package mbox_pkg;
  localparam int VMA_W = 23;
  localparam int WORD_W = 36;
  typedef enum logic [2:0] {IDLE, REQ, RWAIT, PAUSE, DONE} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_RPW} op_t;
endpackage

// File: rtl/mbox_req_seq.sv
// mbox_req_seq: EBOX-side one-at-a-time read/write/RPW sequencer driving mbox strobes (ebox* = EBOX side, mbox* = mbox side; all outputs registered)
module mbox_req_seq
  import mbox_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int PAUSE_TMO = 64
) (
  input  logic              mboxClk,
  input  logic              mboxReset,
  input  logic              eboxReq,
  input  logic              eboxRead,
  input  logic              eboxWrite,
  input  logic              eboxPSE,
  input  logic [VMA_W-1:0]  eboxVMA,
  input  logic [WORD_W-1:0] eboxWriteData,
  output logic              eboxBusy,
  output logic              eboxPaused,
  output logic              eboxDone,
  output logic [WORD_W-1:0] eboxReadData,
  output logic              eboxPauseTmo,
  output logic              mboxReq,
  output logic              mboxRead,
  output logic              mboxWrite,
  output logic              mboxPSE,
  output logic [VMA_W-1:0]  mboxVMA,
  output logic [WORD_W-1:0] mboxDataWrite,
  input  logic [WORD_W-1:0] mboxDataRead
);
  state_t st, st_n;
  op_t op, op_n, new_op;
  logic [3:0] lat, lat_n;
  logic [7:0] pcnt, pcnt_n;
  logic [VMA_W-1:0] vma_n;
  logic [WORD_W-1:0] wd_n, rd_n;
  logic acc, pw, done_n, tmo_n;
  always_comb begin
    acc = eboxReq & ~eboxBusy & (eboxRead | eboxWrite);
    pw = (st == PAUSE) & eboxWrite;
    new_op = eboxRead ? ((eboxPSE | eboxWrite) ? OP_RPW : OP_READ) : OP_WRITE;
    st_n = st;
    op_n = op;
    vma_n = mboxVMA;
    wd_n = mboxDataWrite;
    rd_n = eboxReadData;
    done_n = 1'b0;
    tmo_n = 1'b0;
    if (acc) begin
      st_n = REQ;
      op_n = pw ? OP_WRITE : new_op;
      vma_n = pw ? mboxVMA : eboxVMA;
      wd_n = eboxWriteData;
    end else if (st == REQ) begin
      st_n = (op == OP_WRITE) ? DONE : RWAIT;
      done_n = (op == OP_WRITE);
    end else if (st == RWAIT && lat == 4'(READ_LAT - 1)) begin
      st_n = (op == OP_RPW) ? PAUSE : DONE;
      done_n = 1'b1;
      rd_n = mboxDataRead;
    end else if (st == PAUSE && pcnt == 8'(PAUSE_TMO - 1)) begin
      st_n = IDLE;
      tmo_n = 1'b1;
    end else if (st == DONE) begin
      st_n = IDLE;
    end
    lat_n = (st_n != st) ? 4'd0 : (lat == 4'hf) ? lat : lat + 4'd1;
    pcnt_n = (st_n != st) ? 8'd0 : (pcnt == 8'hff) ? pcnt : pcnt + 8'd1;
  end
  always_ff @(posedge mboxClk) begin
    if (mboxReset) begin
      st <= IDLE;
      op <= OP_READ;
      lat <= '0;
      pcnt <= '0;
      eboxBusy <= 1'b0;
      eboxPaused <= 1'b0;
      eboxDone <= 1'b0;
      eboxReadData <= '0;
      eboxPauseTmo <= 1'b0;
      mboxReq <= 1'b0;
      mboxRead <= 1'b0;
      mboxWrite <= 1'b0;
      mboxPSE <= 1'b0;
      mboxVMA <= '0;
      mboxDataWrite <= '0;
    end else begin
      st <= st_n;
      op <= op_n;
      lat <= lat_n;
      pcnt <= pcnt_n;
      eboxBusy <= (st_n == REQ) || (st_n == RWAIT);
      eboxPaused <= (st_n == PAUSE);
      eboxDone <= done_n;
      eboxReadData <= rd_n;
      eboxPauseTmo <= tmo_n;
      mboxReq <= (st_n == REQ);
      mboxRead <= (st_n == REQ) && (op_n != OP_WRITE);
      mboxWrite <= (st_n == REQ) && (op_n == OP_WRITE);
      mboxPSE <= (st_n == REQ) && (op_n == OP_RPW);
      mboxVMA <= vma_n;
      mboxDataWrite <= wd_n;
    end
  end
endmodule

// File: tb/tb_mbox_req_seq.sv
// tb_mbox_req_seq: directed plus random requests checked cycle by cycle against a transaction-schedule model
module tb_mbox_req_seq;
  import mbox_pkg::*;
  localparam int RL = 1;
  localparam int TMO = 4;
  localparam int N = 4096;
  logic mboxClk = 1'b0;
  logic mboxReset, eboxReq, eboxRead, eboxWrite, eboxPSE;
  logic [VMA_W-1:0] eboxVMA, mboxVMA;
  logic [WORD_W-1:0] eboxWriteData, eboxReadData, mboxDataWrite, mboxDataRead;
  logic eboxBusy, eboxPaused, eboxDone, eboxPauseTmo, mboxReq, mboxRead, mboxWrite, mboxPSE;
  mbox_req_seq #(.READ_LAT(RL), .PAUSE_TMO(TMO)) dut (
    .mboxClk(mboxClk), .mboxReset(mboxReset), .eboxReq(eboxReq), .eboxRead(eboxRead),
    .eboxWrite(eboxWrite), .eboxPSE(eboxPSE), .eboxVMA(eboxVMA), .eboxWriteData(eboxWriteData),
    .eboxBusy(eboxBusy), .eboxPaused(eboxPaused), .eboxDone(eboxDone), .eboxReadData(eboxReadData),
    .eboxPauseTmo(eboxPauseTmo), .mboxReq(mboxReq), .mboxRead(mboxRead), .mboxWrite(mboxWrite),
    .mboxPSE(mboxPSE), .mboxVMA(mboxVMA), .mboxDataWrite(mboxDataWrite), .mboxDataRead(mboxDataRead)
  );
  always #5 mboxClk = ~mboxClk;
  int n_tests = 0, n_fail = 0, c = 0;
  bit e_busy[N], e_req[N], e_rd[N], e_wr[N], e_pse[N], e_done[N], e_paused[N], e_tmo[N], e_rdset[N], e_rdclr[N];
  logic [VMA_W-1:0] e_vma[N];
  logic [WORD_W-1:0] e_wd[N], drv[N];
  int e_rdsrc[N];
  int free_at = 0, pst = 0;
  bit pause_on = 0, fix_on = 0;
  logic [VMA_W-1:0] pvma;
  logic [WORD_W-1:0] m_rdata = '0, fix_val = '0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, c, got, exp);
    end
  endtask
  task automatic model(input logic rs, r, rd, wr, pse, input logic [VMA_W-1:0] v, input logic [WORD_W-1:0] d);
    bit in_p, acc, pw;
    if (rs) begin
      for (int k = c + 1; k < c + 40 && k < N; k++) begin
        e_busy[k] = 0; e_req[k] = 0; e_rd[k] = 0; e_wr[k] = 0; e_pse[k] = 0;
        e_done[k] = 0; e_paused[k] = 0; e_tmo[k] = 0; e_rdset[k] = 0; e_rdclr[k] = 0;
      end
      e_rdclr[c + 1] = 1;
      free_at = c + 1;
      pause_on = 0;
      return;
    end
    in_p = pause_on && c >= pst;
    acc = r && (rd || wr) && c >= free_at;
    if (acc) begin
      pw = in_p && wr;
      if (in_p) pause_on = 0;
      e_busy[c + 1] = 1;
      e_req[c + 1] = 1;
      e_vma[c + 1] = pw ? pvma : v;
      e_wd[c + 1] = d;
      if (pw || !rd) begin
        e_wr[c + 1] = 1;
        e_done[c + 2] = 1;
        free_at = c + 2;
      end else begin
        e_rd[c + 1] = 1;
        e_pse[c + 1] = wr || pse;
        for (int k = 2; k <= RL + 1; k++) e_busy[c + k] = 1;
        e_done[c + RL + 2] = 1;
        e_rdset[c + RL + 2] = 1;
        e_rdsrc[c + RL + 2] = c + RL + 1;
        free_at = c + RL + 2;
        if (wr || pse) begin
          pause_on = 1;
          pst = c + RL + 2;
          pvma = v;
          e_paused[pst] = 1;
        end
      end
    end else if (in_p) begin
      if (c - pst == TMO - 1) begin
        e_tmo[c + 1] = 1;
        pause_on = 0;
      end else e_paused[c + 1] = 1;
    end
  endtask
  task automatic compare();
    if (e_rdclr[c]) begin
      m_rdata = '0;
      chk("vma_after_reset", 64'(mboxVMA), 64'd0);
      chk("wdata_after_reset", 64'(mboxDataWrite), 64'd0);
    end else if (e_rdset[c]) m_rdata = drv[e_rdsrc[c]];
    chk("busy", 64'(eboxBusy), 64'(e_busy[c]));
    chk("mbox_req", 64'(mboxReq), 64'(e_req[c]));
    chk("mbox_read", 64'(mboxRead), 64'(e_rd[c]));
    chk("mbox_write", 64'(mboxWrite), 64'(e_wr[c]));
    chk("mbox_pse", 64'(mboxPSE), 64'(e_pse[c]));
    chk("done", 64'(eboxDone), 64'(e_done[c]));
    chk("paused", 64'(eboxPaused), 64'(e_paused[c]));
    chk("pause_tmo", 64'(eboxPauseTmo), 64'(e_tmo[c]));
    chk("read_data", 64'(eboxReadData), 64'(m_rdata));
    if (e_req[c]) begin
      chk("mbox_vma", 64'(mboxVMA), 64'(e_vma[c]));
      chk("mbox_wdata", 64'(mboxDataWrite), 64'(e_wd[c]));
    end
  endtask
  task automatic step(input logic rs, r, rd, wr, pse, input logic [VMA_W-1:0] v, input logic [WORD_W-1:0] d);
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    mboxReset = rs; eboxReq = r; eboxRead = rd; eboxWrite = wr; eboxPSE = pse;
    eboxVMA = v; eboxWriteData = d;
    mboxDataRead = fix_on ? fix_val : t[WORD_W-1:0];
    drv[c] = mboxDataRead;
    model(rs, r, rd, wr, pse, v, d);
    @(posedge mboxClk);
    #1;
    c++;
    compare();
  endtask
  task automatic idle(input int n);
    logic [63:0] t;
    repeat (n) begin
      t = {$urandom(), $urandom()};
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           t[VMA_W-1:0], t[WORD_W-1:0]);
    end
  endtask
  initial begin
    logic [63:0] t;
    logic rs, r;
    mboxReset = 1'b1; eboxReq = 0; eboxRead = 0; eboxWrite = 0; eboxPSE = 0;
    eboxVMA = '0; eboxWriteData = '0; mboxDataRead = '0;
    step(1, 0, 0, 0, 0, '0, '0);
    step(1, 0, 0, 0, 0, '0, '0);
    idle(1);
    step(0, 1, 0, 1, 0, 23'o100, 36'o123456701234);
    idle(3);
    fix_on = 1; fix_val = 36'o123456701234;
    step(0, 1, 1, 0, 0, 23'o100, '0);
    idle(4);
    step(0, 1, 1, 0, 0, 23'o100, '0);
    idle(2);
    step(0, 1, 1, 0, 0, 23'o101, '0);
    idle(4);
    fix_on = 0;
    step(0, 1, 1, 0, 1, 23'o200, '0);
    idle(4);
    step(0, 1, 0, 1, 0, 23'o777, 36'o55);
    idle(3);
    step(0, 1, 1, 0, 1, 23'o300, '0);
    idle(10);
    step(0, 1, 1, 0, 0, 23'o301, '0);
    idle(4);
    step(0, 1, 1, 0, 0, 23'o400, '0);
    idle(1);
    step(1, 0, 0, 0, 0, '0, '0);
    idle(3);
    for (int i = 0; i < 1500 && c < N - 60; i++) begin
      t = {$urandom(), $urandom()};
      rs = ($urandom_range(0, 199) == 0);
      r = ($urandom_range(0, 99) < 35);
      step(rs, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           t[VMA_W-1:0], {t[WORD_W-1:32], $urandom()});
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
